hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. Sits beside the decode stage and drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers. It resolves three hazards: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits with a watchdog timeout. It also issues a post-reset pipeline flush.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register-file address width.
- WAIT_LIMIT, 255, maximum consecutive memory-wait cycles before timeout (1..255).
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  core clock. One clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source registers of the instruction in D.
- RdE  in  REG_ADDR_WIDTH  destination register of the instruction in E.
- RegWriteE  in  1  instruction in E writes the register file.
- LoadE  in  1  instruction in E is a load.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- DMemReqM  in  1  instruction in M accesses data memory.
- DMemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  insert a bubble into D, E or W.
- MemTimeout  out  1  sticky watchdog error.
- StallCount, FlushCount  out  CNT_WIDTH  performance counters.

## Operation
- FSM states: INIT, RUN, MEM_WAIT, ERR. Reset state is INIT. The wait counter resets to 0, MemTimeout to 0, and both perf counters to 0.
- All stall and flush outputs are combinational (Mealy) functions of the state and the inputs.
- Term definitions:
  - memwait = DMemReqM & ~DMemReadyM.
  - lwstall = LoadE & RegWriteE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
- INIT:
  - Outputs: StallF=1, FlushD=1, FlushE=1, FlushW=1. All other outputs 0.
  - Lasts exactly one cycle, then goes to RUN unconditionally.
- RUN, in priority order:
  1. memwait: StallF, StallD, StallE and StallM =1, FlushW=1. Load the wait counter with 1 and go to MEM_WAIT. Ignore lwstall and PCSrcE this cycle; E is held, so they re-evaluate later.
  2. lwstall: StallF=1, StallD=1, FlushE=1.
  3. PCSrcE: FlushD=1, FlushE=1.
  - lwstall and PCSrcE are mutually exclusive, because a load never branches.
- MEM_WAIT, DMemReadyM=0:
  - Outputs as in RUN case 1. Increment the wait counter.
  - If the counter equals WAIT_LIMIT, go to ERR.
- MEM_WAIT, DMemReadyM=1:
  - Outputs evaluated as in RUN cases 2–3.
  - Clear the wait counter and go to RUN.
  - If DMemReqM is high again, the next cycle treats it as a fresh request.
- ERR:
  - StallF, StallD, StallE and StallM =1, FlushW=1, MemTimeout=1.
  - Stays in ERR until rst_n is asserted.
- Perf counters (saturating, never wrap):
  - StallCount increments on any cycle where StallF=1 outside INIT.
  - FlushCount increments on any cycle where FlushD | FlushE is 1, outside INIT.

## Timing
- Combinational path from inputs to the stall/flush outputs. Zero-cycle latency.
- State, wait counter, MemTimeout and the perf counters are registered and update on the next edge.
- Load-use stall lasts exactly 1 cycle. The next cycle, the load is in M and lwstall drops.
- Branch flush lasts 1 cycle per PCSrcE pulse.
- Memory wait of N cycles with ready on cycle N+1 gives N stall cycles.
- Timeout: ERR is entered after exactly WAIT_LIMIT stalled cycles without ready. MemTimeout is high from the following cycle.
- rst_n assertion in any state, including mid-wait, resets asynchronously. Outputs take their INIT values immediately.
- After rst_n releases, INIT holds for one clock edge.

## Configuration
- HAZARD_CTRL_PERF_EN defined: StallCount and FlushCount are implemented as described.
- Undefined: no counter flops. StallCount and FlushCount are tied to 0.
- All other behaviour is identical with and without the macro.

## Structure
- The shared package pipeline_pkg holds:
  - the FSM state enum hazard_state_t (INIT, RUN, MEM_WAIT, ERR);
  - REG_ADDR_WIDTH;
  - the constant ZERO_REG = 0.
- Sub-module sat_counter (width parameter, inc input, synchronous count output, async active-low reset) is instantiated twice, under HAZARD_CTRL_PERF_EN only.

## Test plan
- Reset, then release → one INIT cycle with FlushD=FlushE=FlushW=StallF=1, then RUN with all outputs 0.
- LoadE=1, RegWriteE=1, RdE=5, Rs2D=5 → StallF=StallD=FlushE=1 for one cycle. Repeat with RdE=0 → no stall.
- PCSrcE=1 for one cycle → FlushD=FlushE=1 that cycle only, and FlushCount increments by 1.
- DMemReqM=1 with DMemReadyM low for 3 cycles, then high → StallF..StallM=1 and FlushW=1 for 3 cycles, then normal flow. StallCount=3.
- WAIT_LIMIT=4, DMemReadyM held low → ERR after 4 wait cycles, MemTimeout=1 and sticky. Asserting rst_n mid-ERR clears it.
- Memory wait coinciding with lwstall → only the memory stall is asserted. The load-use stall appears on the cycle DMemReadyM=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the five-stage RV32I pipeline control.
//   hazard_state_t : hazard controller FSM states (INIT, RUN, MEM_WAIT, ERR)
//   REG_ADDR_WIDTH : register-file address width
//   ZERO_REG       : index of the hard-wired zero register x0
package pipeline_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT,
        ERR
    } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, count updates on the rising edge
//   rst_n : asynchronous active-low reset, clears count
//   inc   : add one to count this cycle (ignored once saturated)
//   count : registered count value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && !(&count))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for load-use, taken-branch and data-memory wait hazards,
// with a memory-wait watchdog and a one-cycle pipeline flush after reset.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   Rs1D, Rs2D                 : source registers of the instruction in D
//   RdE, RegWriteE, LoadE      : destination / write-enable / load flag of the instruction in E
//   PCSrcE                     : branch or jump taken in E
//   DMemReqM, DMemReadyM       : data-memory request in M and its completion
//   StallF/D/E/M               : hold the corresponding pipeline register
//   FlushD/E/W                 : insert a bubble into D, E or W
//   MemTimeout                 : sticky watchdog error
//   StallCount, FlushCount     : saturating performance counters
// Build option: HAZARD_CTRL_PERF_EN implements the performance counters; otherwise they read 0.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH,
    parameter int WAIT_LIMIT     = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic                      RegWriteE,
    input  logic                      LoadE,
    input  logic                      PCSrcE,
    input  logic                      DMemReqM,
    input  logic                      DMemReadyM,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic                      MemTimeout,
    output logic [CNT_WIDTH-1:0]      StallCount,
    output logic [CNT_WIDTH-1:0]      FlushCount
);

    import pipeline_pkg::*;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    hazard_state_t state, state_next;
    logic [7:0]    wait_cnt, wait_next;
    logic          memwait, lwstall;
    logic          in_init, mem_hold, hazard_eval;

    assign memwait = DMemReqM & ~DMemReadyM;
    assign lwstall = LoadE & RegWriteE & (RdE != REG_ADDR_WIDTH'(ZERO_REG))
                   & ((RdE == Rs1D) | (RdE == Rs2D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_next;
            MemTimeout <= MemTimeout | (state_next == ERR);
        end
    end

    always_comb begin
        state_next  = state;
        wait_next   = wait_cnt;
        in_init     = (state == INIT);
        // mem_hold freezes F..M and bubbles W; hazard_eval applies the load-use/branch rules.
        mem_hold    = (state == ERR)
                    | ((state == RUN) & memwait)
                    | ((state == MEM_WAIT) & ~DMemReadyM);
        hazard_eval = ((state == RUN) & ~memwait)
                    | ((state == MEM_WAIT) & DMemReadyM);
        StallF = in_init | mem_hold | (hazard_eval & lwstall);
        StallD = mem_hold | (hazard_eval & lwstall);
        StallE = mem_hold;
        StallM = mem_hold;
        FlushD = in_init | (hazard_eval & ~lwstall & PCSrcE);
        FlushE = in_init | (hazard_eval & (lwstall | PCSrcE));
        FlushW = in_init | mem_hold;
        case (state)
            INIT: state_next = RUN;
            RUN: begin
                if (memwait) begin
                    // The request cycle itself is the first stalled cycle of the wait.
                    wait_next  = 8'd1;
                    state_next = (LIMIT == 8'd1) ? ERR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!DMemReadyM) begin
                    wait_next  = wait_cnt + 8'd1;
                    state_next = (wait_next == LIMIT) ? ERR : MEM_WAIT;
                end else begin
                    wait_next  = '0;
                    state_next = RUN;
                end
            end
            default: state_next = ERR;
        endcase
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic stall_inc, flush_inc;

    assign stall_inc = StallF & ~in_init;
    assign flush_inc = (FlushD | FlushE) & ~in_init;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (StallCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (FlushCount)
    );
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
